sequence_checker: RTL and testbench

Receive-side checker for the fixed 8-byte test pattern AF, BC, E2, 78, FF, E2, 0B, 8D, the same pattern the on-chip sequence generator produces. It samples one byte per valid strobe, acquires byte alignment, declares lock after a configurable number of clean sequences, and then counts completed sequences and byte errors. It sits at the far end of a link under test. It can also be wired directly to the generator, with the generator's enable driving `valid` and its data driving `data`, as a self-check loop.

---
 rtl/sequence_checker.sv | 142 ++++++++++++++
 tb/tb_sequence_checker.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_checker.sv
// Receive-side checker for the 8-byte AF BC E2 78 FF E2 0B 8D test pattern:
// acquires alignment on AF, locks after LOCK_SEQS clean sequences, counts sequences and errors.
module sequence_checker #(
   parameter int LOCK_SEQS   = 2,
   parameter int UNLOCK_ERRS = 4,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid,
   input  logic [7:0]       data,
   output logic             locked,
   output logic             seq_done,
   output logic             err,
   output logic [CNT_W-1:0] seq_count,
   output logic [CNT_W-1:0] err_count
);

   localparam int RUN_W = 4;
   localparam logic [7:0] MARKER = 8'hAF;

   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

   state_t           state, state_n;
   logic [2:0]       idx, idx_n;
   logic [RUN_W-1:0] good_seqs, good_n, good_inc;
   logic [RUN_W-1:0] bad_run, bad_n, bad_inc;
   logic             seq_clean, clean_n, clean_cur;
   logic             done_n, err_n, match;

   function automatic logic [7:0] expected(input logic [2:0] i);
      case (i)
         3'd0:    expected = 8'hAF;
         3'd1:    expected = 8'hBC;
         3'd2:    expected = 8'hE2;
         3'd3:    expected = 8'h78;
         3'd4:    expected = 8'hFF;
         3'd5:    expected = 8'hE2;
         3'd6:    expected = 8'h0B;
         default: expected = 8'h8D;
      endcase
   endfunction

   assign match     = (data == expected(idx));
   assign good_inc  = good_seqs + RUN_W'(1);
   assign bad_inc   = bad_run + RUN_W'(1);
   // a new sequence starts clean at index 0 regardless of history
   assign clean_cur = (idx == 3'd0) | seq_clean;

   always_comb begin
      state_n = state;
      idx_n   = idx;
      good_n  = good_seqs;
      bad_n   = bad_run;
      clean_n = seq_clean;
      done_n  = 1'b0;
      err_n   = 1'b0;
      if (valid) begin
         case (state)
            HUNT: begin
               if (data == MARKER) begin
                  state_n = VERIFY;
                  idx_n   = 3'd1;
                  clean_n = 1'b1;
                  good_n  = '0;
               end
            end
            VERIFY: begin
               if (match) begin
                  idx_n = idx + 3'd1;
                  if (idx == 3'd7) begin
                     done_n = 1'b1;
                     good_n = good_inc;
                     if (good_inc == RUN_W'(LOCK_SEQS)) begin
                        state_n = LOCKED;
                        bad_n   = '0;
                        clean_n = 1'b1;
                     end
                  end
               end else if (data == MARKER) begin
                  idx_n  = 3'd1;
                  good_n = '0;
               end else begin
                  state_n = HUNT;
                  idx_n   = 3'd0;
                  good_n  = '0;
               end
            end
            LOCKED: begin
               // flywheel: index advances on every byte so corruption is tolerated but slips are not
               idx_n = idx + 3'd1;
               if (match) begin
                  bad_n   = '0;
                  clean_n = clean_cur;
                  done_n  = (idx == 3'd7) && clean_cur;
               end else begin
                  err_n   = 1'b1;
                  clean_n = 1'b0;
                  bad_n   = bad_inc;
                  if (bad_inc == RUN_W'(UNLOCK_ERRS)) begin
                     state_n = HUNT;
                     idx_n   = 3'd0;
                     good_n  = '0;
                  end
               end
            end
            default: begin
               state_n = HUNT;
               idx_n   = 3'd0;
               good_n  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= HUNT;
         idx       <= 3'd0;
         good_seqs <= '0;
         bad_run   <= '0;
         seq_clean <= 1'b0;
         seq_done  <= 1'b0;
         err       <= 1'b0;
         seq_count <= '0;
         err_count <= '0;
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         good_seqs <= good_n;
         bad_run   <= bad_n;
         seq_clean <= clean_n;
         seq_done  <= done_n;
         err       <= err_n;
         if (done_n && (seq_count != '1)) seq_count <= seq_count + CNT_W'(1);
         if (err_n && (err_count != '1))  err_count <= err_count + CNT_W'(1);
      end
   end

   assign locked = (state == LOCKED);

endmodule

// File: tb/tb_sequence_checker.sv
// Bench for sequence_checker: two instances (16-bit and 4-bit counters) on one stream,
// compared byte by byte against a behavioural model of the acquisition/lock rules.
module tb_sequence_checker;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       valid = 1'b0;
   logic [7:0] data = 8'h00;

   logic        locked_a, seq_done_a, err_a;
   logic [15:0] seq_count_a, err_count_a;
   logic        locked_b, seq_done_b, err_b;
   logic [3:0]  seq_count_b, err_count_b;

   sequence_checker #(.LOCK_SEQS(2), .UNLOCK_ERRS(4), .CNT_W(16)) dut_a (
      .clk(clk), .reset(reset), .valid(valid), .data(data),
      .locked(locked_a), .seq_done(seq_done_a), .err(err_a),
      .seq_count(seq_count_a), .err_count(err_count_a));

   sequence_checker #(.LOCK_SEQS(2), .UNLOCK_ERRS(4), .CNT_W(4)) dut_b (
      .clk(clk), .reset(reset), .valid(valid), .data(data),
      .locked(locked_b), .seq_done(seq_done_b), .err(err_b),
      .seq_count(seq_count_b), .err_count(err_count_b));

   always #5 clk = ~clk;

   logic [34:0] act_a;
   logic [10:0] act_b;
   assign act_a = {locked_a, seq_done_a, err_a, seq_count_a, err_count_a};
   assign act_b = {locked_b, seq_done_b, err_b, seq_count_b, err_count_b};

   int total = 0;
   int bad = 0;

   logic [7:0] pat [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};

   // behavioural model: 0 = hunting, 1 = verifying, 2 = locked
   int   m_mode, m_pos, m_good, m_bad, m_seqc, m_errc;
   logic m_clean, m_done, m_err;

   function automatic int sat(input int v, input int w);
      return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
   endfunction

   function automatic logic [34:0] exp_a();
      return {(m_mode == 2), m_done, m_err, 16'(sat(m_seqc, 16)), 16'(sat(m_errc, 16))};
   endfunction

   function automatic logic [10:0] exp_b();
      return {(m_mode == 2), m_done, m_err, 4'(sat(m_seqc, 4)), 4'(sat(m_errc, 4))};
   endfunction

   task automatic model_reset();
      m_mode = 0; m_pos = 0; m_good = 0; m_bad = 0; m_seqc = 0; m_errc = 0;
      m_clean = 1'b0; m_done = 1'b0; m_err = 1'b0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      m_done = 1'b0;
      m_err  = 1'b0;
      if (m_mode == 0) begin
         if (b == 8'hAF) begin m_mode = 1; m_pos = 1; m_good = 0; m_clean = 1'b1; end
      end else if (m_mode == 1) begin
         if (b == pat[m_pos]) begin
            if (m_pos == 7) begin
               m_done = 1'b1;
               m_good++;
               if (m_good == 2) begin m_mode = 2; m_bad = 0; m_clean = 1'b1; end
            end
            m_pos = (m_pos + 1) % 8;
         end else if (b == 8'hAF) begin
            m_pos = 1; m_good = 0;
         end else begin
            m_mode = 0; m_pos = 0; m_good = 0;
         end
      end else begin
         if (m_pos == 0) m_clean = 1'b1;
         if (b == pat[m_pos]) begin
            m_bad = 0;
            if (m_pos == 7 && m_clean) m_done = 1'b1;
         end else begin
            m_err = 1'b1; m_clean = 1'b0; m_bad++;
         end
         m_pos = (m_pos + 1) % 8;
         if (m_bad == 4) begin m_mode = 0; m_pos = 0; m_good = 0; end
      end
      if (m_done) m_seqc++;
      if (m_err)  m_errc++;
   endtask

   task automatic push(input logic [7:0] b);
      data  = b;
      valid = 1'b1;
      @(posedge clk);
      #1;
      valid = 1'b0;
      data  = $urandom_range(0, 255);
      model_byte(b);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      m_done = 1'b0;
      m_err  = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (act_a !== 35'd0) begin bad++; $display("FAIL reset_a: got %h want 0", act_a); end
      total++;
      if (act_b !== 11'd0) begin bad++; $display("FAIL reset_b: got %h want 0", act_b); end
   endtask

   task automatic test_acquire();
      do_reset();
      for (int i = 0; i < 24; i++) begin
         push(pat[i % 8]);
         total++;
         if (act_a !== exp_a()) begin bad++; $display("FAIL acquire byte %0d: got %h want %h", i + 1, act_a, exp_a()); end
         if (i == 15) begin
            total++;
            if (locked_a !== 1'b1 || seq_done_a !== 1'b1) begin
               bad++; $display("FAIL acquire_lock16: got locked=%b done=%b want 1 1", locked_a, seq_done_a);
            end
         end
      end
      total++;
      if (seq_count_a !== 16'd3 || err_count_a !== 16'd0) begin
         bad++; $display("FAIL acquire_counts: got seq=%0d err=%0d want 3 0", seq_count_a, err_count_a);
      end
   endtask

   task automatic test_gapped();
      do_reset();
      for (int i = 0; i < 24; i++) begin
         push(pat[i % 8]);
         total++;
         if (act_a !== exp_a()) begin bad++; $display("FAIL gapped byte %0d: got %h want %h", i + 1, act_a, exp_a()); end
         repeat ($urandom_range(1, 3)) begin
            idle();
            total++;
            if (seq_done_a !== 1'b0 || err_a !== 1'b0 || act_a !== exp_a()) begin
               bad++; $display("FAIL gapped gap after %0d: got %h want %h", i + 1, act_a, exp_a());
            end
         end
      end
      total++;
      if (seq_count_a !== 16'd3 || err_count_a !== 16'd0 || locked_a !== 1'b1) begin
         bad++; $display("FAIL gapped_counts: got seq=%0d err=%0d lk=%b want 3 0 1", seq_count_a, err_count_a, locked_a);
      end
   endtask

   task automatic test_false_start();
      logic [7:0] s [13] = '{8'h00, 8'hE2, 8'h78, 8'hAF, 8'hBC, 8'hAF, 8'hBC,
                             8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};
      do_reset();
      for (int i = 0; i < 13; i++) begin
         push(s[i]);
         total++;
         if (act_a !== exp_a()) begin bad++; $display("FAIL false_start byte %0d: got %h want %h", i + 1, act_a, exp_a()); end
         if (i < 12) begin
            total++;
            if (seq_done_a !== 1'b0) begin bad++; $display("FAIL false_start early_done byte %0d: got 1 want 0", i + 1); end
         end
      end
      total++;
      if (seq_done_a !== 1'b1 || seq_count_a !== 16'd1 || locked_a !== 1'b0) begin
         bad++; $display("FAIL false_start_end: got done=%b seq=%0d lk=%b want 1 1 0", seq_done_a, seq_count_a, locked_a);
      end
   endtask

   task automatic test_corruption();
      do_reset();
      for (int i = 0; i < 32; i++) begin
         push((i == 20) ? 8'hFE : pat[i % 8]);
         total++;
         if (act_a !== exp_a()) begin bad++; $display("FAIL corruption byte %0d: got %h want %h", i + 1, act_a, exp_a()); end
         if (i == 20) begin
            total++;
            if (err_a !== 1'b1 || locked_a !== 1'b1) begin bad++; $display("FAIL corruption_err: got err=%b lk=%b want 1 1", err_a, locked_a); end
         end
         if (i == 23) begin
            total++;
            if (seq_done_a !== 1'b0) begin bad++; $display("FAIL corruption_nodone: got 1 want 0"); end
         end
         if (i == 31) begin
            total++;
            if (seq_done_a !== 1'b1) begin bad++; $display("FAIL corruption_resume: got 0 want 1"); end
         end
      end
      total++;
      if (err_count_a !== 16'd1 || seq_count_a !== 16'd3 || locked_a !== 1'b1) begin
         bad++; $display("FAIL corruption_counts: got err=%0d seq=%0d lk=%b want 1 3 1", err_count_a, seq_count_a, locked_a);
      end
   endtask

   task automatic test_loss_of_lock();
      do_reset();
      for (int i = 0; i < 16; i++) push(pat[i % 8]);
      for (int i = 0; i < 4; i++) begin
         push(8'h00);
         total++;
         if (act_a !== exp_a()) begin bad++; $display("FAIL loss byte %0d: got %h want %h", i + 1, act_a, exp_a()); end
      end
      total++;
      if (err_count_a !== 16'd4 || locked_a !== 1'b0 || err_a !== 1'b1) begin
         bad++; $display("FAIL loss_unlock: got err_cnt=%0d lk=%b err=%b want 4 0 1", err_count_a, locked_a, err_a);
      end
      for (int i = 0; i < 16; i++) begin
         push(pat[i % 8]);
         total++;
         if (act_a !== exp_a()) begin bad++; $display("FAIL relock byte %0d: got %h want %h", i + 1, act_a, exp_a()); end
      end
      total++;
      if (locked_a !== 1'b1 || seq_count_a !== 16'd4) begin
         bad++; $display("FAIL relock: got lk=%b seq=%0d want 1 4", locked_a, seq_count_a);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 20; i++) push(pat[i % 8]);
      data  = pat[4];
      valid = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      total++;
      if (act_a !== 35'd0) begin bad++; $display("FAIL async_reset_a: got %h want 0", act_a); end
      total++;
      if (act_b !== 11'd0) begin bad++; $display("FAIL async_reset_b: got %h want 0", act_b); end
      valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 16; i++) push(pat[i % 8]);
      total++;
      if (act_a !== exp_a() || locked_a !== 1'b1) begin bad++; $display("FAIL async_reacquire: got %h want %h", act_a, exp_a()); end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 160; i++) begin
         push(pat[i % 8]);
         total++;
         if (act_b !== exp_b()) begin bad++; $display("FAIL sat byte %0d: got %h want %h", i + 1, act_b, exp_b()); end
      end
      total++;
      if (seq_count_b !== 4'd15 || seq_count_a !== 16'd20) begin
         bad++; $display("FAIL saturation: got b=%0d a=%0d want 15 20", seq_count_b, seq_count_a);
      end
   endtask

   task automatic test_random();
      int n;
      do_reset();
      for (int s = 0; s < 60; s++) begin
         int kind = $urandom_range(0, 9);
         int where = $urandom_range(0, 7);
         if (kind == 9) begin
            repeat ($urandom_range(1, 3)) push($urandom_range(0, 255));
         end
         for (int p = 0; p < 8; p++) begin
            if (kind == 8 && p == where) continue;
            push((kind == 7 && p == where) ? 8'($urandom_range(0, 255)) : pat[p]);
            n++;
            total++;
            if (act_a !== exp_a()) begin bad++; $display("FAIL random_a seq %0d pos %0d: got %h want %h", s, p, act_a, exp_a()); end
            total++;
            if (act_b !== exp_b()) begin bad++; $display("FAIL random_b seq %0d pos %0d: got %h want %h", s, p, act_b, exp_b()); end
            if ($urandom_range(0, 3) == 0) idle();
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_acquire();
      test_gapped();
      test_false_start();
      test_corruption();
      test_loss_of_lock();
      test_async_reset();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
